// File: rtl/ball_motion.sv
// ball_motion: moves the ball one cell per tick on the 16x12 grid, reflecting off walls, bricks and the paddle.
module ball_motion #(
  parameter logic [3:0] PADDLE_ROW = 4'd10,
  parameter logic [3:0] PADDLE_W   = 4'd4,
  parameter logic [3:0] BRICK_ROWS = 4'd5,
  parameter logic [3:0] LOST_ROW   = 4'd11
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        tick_i,
  input  logic        launch_i,
  input  logic        halt_i,
  input  logic [3:0]  paddle_col_i,
  input  logic [71:0] bricks_i,
  output logic [3:0]  ball_row_index_o,
  output logic [3:0]  ball_col_index_o,
  output logic [1:0]  ball_direction_o,
  output logic        ball_active_o,
  output logic        ball_lost_o
);
  typedef enum logic [1:0] {IDLE, RUN, LOST} state_t;
  // 16 - PADDLE_W, taken modulo 16
  localparam logic [3:0] PC_MAX = 4'd0 - PADDLE_W;
  state_t state_q, state_d;
  logic [3:0] row_q, row_d, col_q, col_d;
  logic [1:0] dir_q, dir_d;
  logic active_q, lost_q;
  logic [3:0] pc, park_col, nr, nc;
  logic a_down, a_right, pad_hit, v, h, d, flip_v, flip_h, park;
  function automatic logic brick(input logic [71:0] b, input logic [3:0] r, input logic [3:0] c);
    logic [3:0] rm;
    rm = r - 4'd1;
    return (r >= 4'd1 && r <= BRICK_ROWS) ? b[{1'b0, rm[2:0], c[3:1]}] : 1'b0;
  endfunction
  always_comb begin
    pc = (paddle_col_i > PC_MAX) ? PC_MAX : paddle_col_i;
    park_col = pc + (PADDLE_W >> 1) - 4'd1;
    a_down = dir_q[1] | (row_q == 4'd0);
    a_right = dir_q[0] ? (col_q != 4'd15) : (col_q == 4'd0);
    nr = a_down ? row_q + 4'd1 : row_q - 4'd1;
    nc = a_right ? col_q + 4'd1 : col_q - 4'd1;
    pad_hit = a_down && (row_q + 4'd1 == PADDLE_ROW) && nc >= pc && nc <= pc + PADDLE_W - 4'd1;
    v = brick(bricks_i, nr, col_q);
    h = brick(bricks_i, row_q, nc);
    d = brick(bricks_i, nr, nc);
    // a lone diagonal brick reflects like a corner hit
    flip_v = v | (~h & d);
    flip_h = h | (~v & d);
    park = (state_q == IDLE) || (state_q == LOST && launch_i);
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    dir_d = dir_q;
    if (park) begin
      row_d = PADDLE_ROW - 4'd1;
      col_d = park_col;
      dir_d = 2'b01;
      state_d = (state_q == IDLE && launch_i) ? RUN : IDLE;
    end else if (state_q == RUN && tick_i && !halt_i) begin
      if (pad_hit) dir_d = {1'b0, nc >= pc + (PADDLE_W >> 1)};
      else if (flip_v | flip_h) dir_d = {a_down ^ flip_v, a_right ^ flip_h};
      else begin
        row_d = nr;
        col_d = nc;
        dir_d = {a_down, a_right};
        state_d = (nr == LOST_ROW) ? LOST : RUN;
      end
    end
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      row_q <= PADDLE_ROW - 4'd1;
      col_q <= park_col;
      dir_q <= 2'b01;
      active_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      dir_q <= dir_d;
      active_q <= (state_d == RUN);
      lost_q <= (state_d == LOST);
    end
  end
  assign ball_row_index_o = row_q;
  assign ball_col_index_o = col_q;
  assign ball_direction_o = dir_q;
  assign ball_active_o = active_q;
  assign ball_lost_o = lost_q;
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed trajectories through walls, bricks, paddle, loss, pause and reset.
module tb_ball_motion;
  logic clk = 1'b0;
  logic reset = 1'b1, tick = 1'b0, launch = 1'b0, halt = 1'b0;
  logic [3:0] paddle = 4'd6;
  logic [71:0] bricks = '0;
  logic [3:0] row, col;
  logic [1:0] dir;
  logic act, lst;
  int vecs = 0, errs = 0;
  ball_motion dut (
    .clock_i(clk), .reset_i(reset), .tick_i(tick), .launch_i(launch), .halt_i(halt),
    .paddle_col_i(paddle), .bricks_i(bricks),
    .ball_row_index_o(row), .ball_col_index_o(col), .ball_direction_o(dir),
    .ball_active_o(act), .ball_lost_o(lst)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic expect_ball(input string tag, input logic [3:0] r, input logic [3:0] c,
                             input logic [1:0] d, input logic a, input logic l);
    chk(tag, {20'd0, row, col, dir, act, lst}, {20'd0, r, c, d, a, l});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask
  task automatic pulse_launch();
    launch = 1'b1;
    step();
    launch = 1'b0;
  endtask
  task automatic restart(input logic [3:0] p);
    reset = 1'b1;
    paddle = p;
    bricks = '0;
    step();
    reset = 1'b0;
    pulse_launch();
  endtask
  initial begin
    step();
    step();
    reset = 1'b0;
    expect_ball("reset", 4'd9, 4'd7, 2'b01, 1'b0, 1'b0);
    step();
    expect_ball("idle_hold", 4'd9, 4'd7, 2'b01, 1'b0, 1'b0);
    pulse_launch();
    expect_ball("launch", 4'd9, 4'd7, 2'b01, 1'b1, 1'b0);
    ticks(1);
    expect_ball("run_t1", 4'd8, 4'd8, 2'b01, 1'b1, 1'b0);
    ticks(1);
    expect_ball("run_t2", 4'd7, 4'd9, 2'b01, 1'b1, 1'b0);
    step();
    expect_ball("no_tick_hold", 4'd7, 4'd9, 2'b01, 1'b1, 1'b0);
    halt = 1'b1;
    ticks(3);
    halt = 1'b0;
    expect_ball("halt", 4'd7, 4'd9, 2'b01, 1'b1, 1'b0);
    reset = 1'b1;
    tick = 1'b1;
    step();
    reset = 1'b0;
    tick = 1'b0;
    expect_ball("reset_mid_run", 4'd9, 4'd7, 2'b01, 1'b0, 1'b0);
    paddle = 4'd14;
    step();
    expect_ball("park_clamp", 4'd9, 4'd13, 2'b01, 1'b0, 1'b0);
    // right and top walls
    restart(4'd8);
    ticks(6);
    expect_ball("to_right_wall", 4'd3, 4'd15, 2'b01, 1'b1, 1'b0);
    ticks(1);
    expect_ball("right_wall", 4'd2, 4'd14, 2'b00, 1'b1, 1'b0);
    ticks(2);
    expect_ball("to_top", 4'd0, 4'd12, 2'b00, 1'b1, 1'b0);
    ticks(1);
    expect_ball("top_wall", 4'd1, 4'd11, 2'b10, 1'b1, 1'b0);
    // vertical brick, then miss the paddle and get lost
    restart(4'd0);
    ticks(3);
    expect_ball("v_pre", 4'd6, 4'd4, 2'b01, 1'b1, 1'b0);
    bricks[34] = 1'b1;
    ticks(1);
    expect_ball("v_brick", 4'd6, 4'd4, 2'b11, 1'b1, 1'b0);
    ticks(1);
    expect_ball("v_after", 4'd7, 4'd5, 2'b11, 1'b1, 1'b0);
    ticks(3);
    expect_ball("miss_row10", 4'd10, 4'd8, 2'b11, 1'b1, 1'b0);
    ticks(1);
    expect_ball("lost", 4'd11, 4'd9, 2'b11, 1'b0, 1'b1);
    ticks(2);
    expect_ball("lost_hold", 4'd11, 4'd9, 2'b11, 1'b0, 1'b1);
    pulse_launch();
    expect_ball("lost_relaunch", 4'd9, 4'd1, 2'b01, 1'b0, 1'b0);
    // diagonal-only brick
    restart(4'd1);
    ticks(3);
    bricks[35] = 1'b1;
    ticks(1);
    expect_ball("d_brick", 4'd6, 4'd5, 2'b10, 1'b1, 1'b0);
    ticks(1);
    expect_ball("d_after", 4'd7, 4'd4, 2'b10, 1'b1, 1'b0);
    // horizontal brick
    restart(4'd1);
    ticks(4);
    expect_ball("h_pre", 4'd5, 4'd6, 2'b01, 1'b1, 1'b0);
    bricks[35] = 1'b1;
    ticks(1);
    expect_ball("h_brick", 4'd5, 4'd6, 2'b00, 1'b1, 1'b0);
    ticks(1);
    expect_ball("h_after", 4'd4, 4'd5, 2'b00, 1'b1, 1'b0);
    // paddle hits, left wall, loss on the far side
    restart(4'd0);
    ticks(9);
    expect_ball("p_top", 4'd0, 4'd10, 2'b01, 1'b1, 1'b0);
    ticks(1);
    expect_ball("p_topbounce", 4'd1, 4'd11, 2'b11, 1'b1, 1'b0);
    ticks(4);
    expect_ball("p_right", 4'd5, 4'd15, 2'b11, 1'b1, 1'b0);
    ticks(1);
    expect_ball("p_rightbounce", 4'd6, 4'd14, 2'b10, 1'b1, 1'b0);
    ticks(3);
    expect_ball("p_above1", 4'd9, 4'd11, 2'b10, 1'b1, 1'b0);
    paddle = 4'd8;
    ticks(1);
    expect_ball("paddle_right", 4'd9, 4'd11, 2'b01, 1'b1, 1'b0);
    ticks(5);
    expect_ball("p_rw2", 4'd4, 4'd14, 2'b00, 1'b1, 1'b0);
    ticks(5);
    expect_ball("p_top2", 4'd1, 4'd9, 2'b10, 1'b1, 1'b0);
    ticks(8);
    expect_ball("p_above2", 4'd9, 4'd1, 2'b10, 1'b1, 1'b0);
    paddle = 4'd0;
    ticks(1);
    expect_ball("paddle_left", 4'd9, 4'd1, 2'b00, 1'b1, 1'b0);
    ticks(1);
    expect_ball("p_col0", 4'd8, 4'd0, 2'b00, 1'b1, 1'b0);
    ticks(1);
    expect_ball("left_wall", 4'd7, 4'd1, 2'b01, 1'b1, 1'b0);
    ticks(8);
    expect_ball("p_top3", 4'd1, 4'd9, 2'b11, 1'b1, 1'b0);
    ticks(8);
    expect_ball("p_above3", 4'd9, 4'd13, 2'b10, 1'b1, 1'b0);
    ticks(1);
    expect_ball("p_miss", 4'd10, 4'd12, 2'b10, 1'b1, 1'b0);
    ticks(1);
    expect_ball("p_lost", 4'd11, 4'd11, 2'b10, 1'b0, 1'b1);
    pulse_launch();
    expect_ball("p_relaunch", 4'd9, 4'd1, 2'b01, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
